// File: rtl/game_pkg.sv
// Shared game-wide types and constants: board size defaults, difficulty
// presets, mine placer state encoding and the LFSR seed/step function.
package game_pkg;

    localparam int MAX_ROWS_DEF = 16;
    localparam int MAX_COLS_DEF = 30;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [4:0] rows;
        logic [4:0] cols;
        logic [6:0] mines;
    } preset_t;

    localparam preset_t PRESET_BEGINNER     = '{rows: 5'd9,  cols: 5'd9,  mines: 7'd10};
    localparam preset_t PRESET_INTERMEDIATE = '{rows: 5'd16, cols: 5'd16, mines: 7'd40};
    localparam preset_t PRESET_EXPERT       = '{rows: 5'd16, cols: 5'd30, mines: 7'd99};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        DRAW  = 3'd2,
        CHECK = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } placer_state_t;

    // Fibonacci step for x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit maximal-length LFSR; never allowed to rest in the
// all-zero lock-up state.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next value: recover from the lock-up state, otherwise take one step.
    always_comb begin
        state_d = state_q;
        if (state_q == 16'h0000) begin
            state_d = LFSR_SEED;
        end else begin
            state_d = lfsr_next(state_q);
        end
    end

    // Sequence register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign out = state_q;

endmodule

// File: rtl/mine_placer.sv
// Clears the board mine map, then rejection-samples mine positions from a
// free-running LFSR. Define MINE_PLACER_SAFE_ZONE_EN to keep the whole 3x3
// neighbourhood of the first click free instead of just the clicked cell.
module mine_placer
    import game_pkg::*;
#(
    parameter int MAX_ROWS = MAX_ROWS_DEF,
    parameter int MAX_COLS = MAX_COLS_DEF,
    parameter int ROW_W    = 5,
    parameter int COL_W    = 5,
    parameter int ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  rows,
    input  logic [COL_W-1:0]  cols,
    input  logic [6:0]        mine_count,
    input  logic [ROW_W-1:0]  safe_row,
    input  logic [COL_W-1:0]  safe_col,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic              mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic [6:0]        placed
);

    localparam int CELLS = MAX_ROWS * MAX_COLS;
    localparam int CW    = ROW_W + COL_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [ROW_W:0]    ROW_ONE   = {{ROW_W{1'b0}}, 1'b1};
    localparam logic [COL_W:0]    COL_ONE   = {{COL_W{1'b0}}, 1'b1};

    placer_state_t     state_q, state_d;
    logic [ROW_W-1:0]  rows_q, srow_q;
    logic [COL_W-1:0]  cols_q, scol_q;
    logic [6:0]        n_q, placed_q;
    logic [ADDR_W-1:0] idx_q, cand_q;

    logic [15:0]       lfsr_s;
    logic              lfsr_unused_s;
    logic [ROW_W-1:0]  cand_row_s;
    logic [COL_W-1:0]  cand_col_s;
    logic [ADDR_W-1:0] cand_addr_s;
    logic              excl_s;
    logic              cand_ok_s;
    logic [CW-1:0]     cells_s, excl_cells_s, avail_s;
    logic [6:0]        n_eff_s;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s[15:ROW_W+COL_W];
    assign cand_row_s    = lfsr_s[ROW_W-1:0];
    assign cand_col_s    = lfsr_s[ROW_W+COL_W-1:ROW_W];
    assign cand_addr_s   = ADDR_W'(cand_row_s) * ADDR_W'(MAX_COLS) + ADDR_W'(cand_col_s);

`ifdef MINE_PLACER_SAFE_ZONE_EN
    logic [1:0] zone_r_s, zone_c_s;

    // Candidate is excluded when within one row and one column of the safe cell.
    assign excl_s = ({1'b0, cand_row_s} + ROW_ONE >= {1'b0, srow_q}) &&
                    ({1'b0, cand_row_s} <= {1'b0, srow_q} + ROW_ONE) &&
                    ({1'b0, cand_col_s} + COL_ONE >= {1'b0, scol_q}) &&
                    ({1'b0, cand_col_s} <= {1'b0, scol_q} + COL_ONE);

    assign zone_r_s = 2'd1 + 2'(safe_row != {ROW_W{1'b0}})
                           + 2'(({1'b0, safe_row} + ROW_ONE) < {1'b0, rows});
    assign zone_c_s = 2'd1 + 2'(safe_col != {COL_W{1'b0}})
                           + 2'(({1'b0, safe_col} + COL_ONE) < {1'b0, cols});
    assign excl_cells_s = CW'(zone_r_s) * CW'(zone_c_s);
`else
    assign excl_s       = (cand_row_s == srow_q) && (cand_col_s == scol_q);
    assign excl_cells_s = CW'(1'b1);
`endif

    assign cand_ok_s = (cand_row_s < rows_q) && (cand_col_s < cols_q) && !excl_s;

    // Clamp the request to the cells actually available for mines.
    assign cells_s = CW'(rows) * CW'(cols);
    assign avail_s = (cells_s > excl_cells_s) ? (cells_s - excl_cells_s) : {CW{1'b0}};
    assign n_eff_s = (CW'(mine_count) < avail_s) ? mine_count : avail_s[6:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
                else       state_d = IDLE;
            end
            CLEAR: begin
                if (idx_q == LAST_ADDR) state_d = (n_q == 7'd0) ? DONE : DRAW;
                else                    state_d = CLEAR;
            end
            DRAW: begin
                if (cand_ok_s) state_d = CHECK;
                else           state_d = DRAW;
            end
            CHECK: begin
                if (mem_rd_data) state_d = DRAW;
                else             state_d = WRITE;
            end
            WRITE: begin
                if (placed_q + 7'd1 == n_q) state_d = DONE;
                else                        state_d = DRAW;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Run parameters, clear pointer, accepted candidate and mine counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q   <= {ROW_W{1'b0}};
            cols_q   <= {COL_W{1'b0}};
            srow_q   <= {ROW_W{1'b0}};
            scol_q   <= {COL_W{1'b0}};
            n_q      <= 7'd0;
            placed_q <= 7'd0;
            idx_q    <= {ADDR_W{1'b0}};
            cand_q   <= {ADDR_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rows_q   <= rows;
                        cols_q   <= cols;
                        srow_q   <= safe_row;
                        scol_q   <= safe_col;
                        n_q      <= n_eff_s;
                        placed_q <= 7'd0;
                        idx_q    <= {ADDR_W{1'b0}};
                    end
                end
                CLEAR:   idx_q    <= idx_q + ADDR_W'(1'b1);
                DRAW:    cand_q   <= cand_ok_s ? cand_addr_s : cand_q;
                WRITE:   placed_q <= placed_q + 7'd1;
                default: idx_q    <= idx_q;
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        mem_rd_addr = {ADDR_W{1'b0}};
        mem_wr_en   = 1'b0;
        mem_wr_addr = {ADDR_W{1'b0}};
        mem_wr_data = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = idx_q;
                busy        = 1'b1;
            end
            DRAW: begin
                mem_rd_addr = cand_ok_s ? cand_addr_s : {ADDR_W{1'b0}};
                busy        = 1'b1;
            end
            CHECK: busy = 1'b1;
            WRITE: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = cand_q;
                mem_wr_data = 1'b1;
                busy        = 1'b1;
            end
            DONE:    done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign placed = placed_q;

endmodule

// File: tb/tb_mine_placer.sv
// Self-checking bench for mine_placer: board RAM model, write monitor and
// table/random runs judged against the placement rules.
module tb_mine_placer;

    logic       clk, rst, start;
    logic [4:0] rows, cols, safe_row, safe_col;
    logic [6:0] mine_count, placed;
    logic [8:0] mem_rd_addr, mem_wr_addr;
    logic       mem_rd_data, mem_wr_en, mem_wr_data, busy, done;

    mine_placer dut (
        .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
        .mine_count(mine_count), .safe_row(safe_row), .safe_col(safe_col),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .done(done), .placed(placed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit ram [480];
    always @(posedge clk) begin
        mem_rd_data <= (int'(mem_rd_addr) < 480) ? ram[mem_rd_addr] : 1'b0;
        if (mem_wr_en && int'(mem_wr_addr) < 480) ram[mem_wr_addr] <= mem_wr_data;
    end

    typedef struct {
        int    r, c, m, sr, sc;
        int    exp_n;
        string name;
    } vec_t;

    int checks = 0, failures = 0;
    int cur_rows, cur_cols, cur_sr, cur_sc;
    int n_zero, n_one, order_err, dup_err, excl_err, bound_err, bd_err;
    int done_cnt, busy_cycles, cyc, last_zero_cyc, wa;
    logic [479:0] ones_map;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic bit in_bounds(input int a);
        return (a < 480) && (a / 30 < cur_rows) && (a % 30 < cur_cols);
    endfunction

    function automatic bit excluded(input int r, input int c);
`ifdef MINE_PLACER_SAFE_ZONE_EN
        return (r >= cur_sr - 1) && (r <= cur_sr + 1) && (c >= cur_sc - 1) && (c <= cur_sc + 1);
`else
        return (r == cur_sr) && (c == cur_sc);
`endif
    endfunction

    // Reference count: requested mines clipped to the cells left outside the exclusion.
    function automatic int model_n(input int r, input int c, input int m, input int sr, input int sc);
        int excl, avail;
`ifdef MINE_PLACER_SAFE_ZONE_EN
        excl = ((sr > 0 ? 1 : 0) + 1 + (sr + 1 < r ? 1 : 0)) *
               ((sc > 0 ? 1 : 0) + 1 + (sc + 1 < c ? 1 : 0));
`else
        excl = 1;
`endif
        avail = (r * c > excl) ? r * c - excl : 0;
        return (m < avail) ? m : avail;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (busy) begin
                busy_cycles++;
                if (!in_bounds(int'(mem_rd_addr))) bound_err++;
            end
            if (done) begin
                done_cnt++;
                if (busy) bd_err++;
            end
            if (mem_wr_en) begin
                if (!busy) bd_err++;
                wa = int'(mem_wr_addr);
                if (mem_wr_data == 1'b0) begin
                    if (wa != n_zero || n_one != 0 || (n_zero > 0 && cyc != last_zero_cyc + 1))
                        order_err++;
                    last_zero_cyc = cyc;
                    n_zero++;
                end else begin
                    if (!in_bounds(wa)) bound_err++;
                    if (excluded(wa / 30, wa % 30)) excl_err++;
                    if (wa < 480) begin
                        if (ones_map[wa]) dup_err++;
                        ones_map[wa] = 1'b1;
                    end
                    n_one++;
                end
            end
        end
    end

    task automatic clear_stats();
        n_zero = 0; n_one = 0; order_err = 0; dup_err = 0; excl_err = 0;
        bound_err = 0; bd_err = 0; done_cnt = 0; busy_cycles = 0; ones_map = '0;
    endtask

    task automatic pulse_start(input vec_t v);
        @(negedge clk);
        rows = 5'(v.r); cols = 5'(v.c); mine_count = 7'(v.m);
        safe_row = 5'(v.sr); safe_col = 5'(v.sc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string nm);
        int k = 0;
        while (done_cnt == 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_done_seen"}, (done_cnt > 0) ? 1 : 0, 1);
    endtask

    task automatic run_case(input vec_t v);
        cur_rows = v.r; cur_cols = v.c; cur_sr = v.sr; cur_sc = v.sc;
        clear_stats();
        pulse_start(v);
        wait_done(40000, v.name);
        repeat (3) @(negedge clk);
        check({v.name, "_placed"}, int'(placed), v.exp_n);
        check({v.name, "_done_pulses"}, done_cnt, 1);
        check({v.name, "_clear_writes"}, n_zero, 480);
        check({v.name, "_clear_order"}, order_err, 0);
        check({v.name, "_mine_writes"}, n_one, v.exp_n);
        check({v.name, "_dup_excl_bound"}, dup_err + excl_err + bound_err + bd_err, 0);
        check({v.name, "_latency_ok"},
              ((v.exp_n == 0) ? (busy_cycles == 480) : (busy_cycles >= 480 + 3 * v.exp_n)) ? 1 : 0, 1);
    endtask

    vec_t vecs [8];
    logic [479:0] maps [20];
    logic [479:0] exp_map;
    vec_t v;

    initial begin
        rst = 1'b1; start = 1'b0; rows = '0; cols = '0; mine_count = '0;
        safe_row = '0; safe_col = '0; cyc = 0; last_zero_cyc = 0;
        clear_stats();

`ifdef MINE_PLACER_SAFE_ZONE_EN
        vecs[0] = '{9, 9, 10, 4, 4, 10, "beginner"};
        vecs[1] = '{2, 2, 99, 0, 0, 0, "tiny2x2"};
        vecs[4] = '{3, 3, 99, 1, 1, 0, "center3x3"};
        vecs[7] = '{4, 5, 99, 0, 2, 14, "edge4x5"};
`else
        vecs[0] = '{9, 9, 10, 4, 4, 10, "beginner"};
        vecs[1] = '{2, 2, 99, 0, 0, 3, "tiny2x2"};
        vecs[4] = '{3, 3, 99, 1, 1, 8, "center3x3"};
        vecs[7] = '{4, 5, 99, 0, 2, 19, "edge4x5"};
`endif
        vecs[2] = '{16, 30, 99, 15, 29, 99, "expert"};
        vecs[3] = '{1, 1, 5, 0, 0, 0, "single"};
        vecs[5] = '{9, 9, 0, 0, 0, 0, "zero_req"};
        vecs[6] = '{16, 16, 40, 0, 15, 40, "intermediate"};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr_en", int'(mem_wr_en), 0);
        check("rst_wr_addr", int'(mem_wr_addr), 0);
        check("rst_wr_data", int'(mem_wr_data), 0);
        check("rst_rd_addr", int'(mem_rd_addr), 0);
        check("rst_placed", int'(placed), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_case(vecs[i]);
            if (i == 1) begin
                exp_map = '0;
`ifndef MINE_PLACER_SAFE_ZONE_EN
                exp_map[1] = 1'b1; exp_map[30] = 1'b1; exp_map[31] = 1'b1;
`endif
                check("tiny2x2_map", (ones_map == exp_map) ? 1 : 0, 1);
            end
        end

        // Second start 5 cycles after the first must be dropped.
        cur_rows = 9; cur_cols = 9; cur_sr = 4; cur_sc = 4;
        clear_stats();
        pulse_start(vecs[0]);
        repeat (3) @(negedge clk);
        v = '{2, 2, 1, 1, 1, 0, "dropped"};
        pulse_start(v);
        wait_done(40000, "dbl");
        repeat (600) @(negedge clk);
        check("dbl_done_pulses", done_cnt, 1);
        check("dbl_placed", int'(placed), 10);
        check("dbl_mine_writes", n_one, 10);
        check("dbl_busy_after", int'(busy), 0);

        // Reset in the middle of drawing, then a clean run.
        cur_rows = 16; cur_cols = 30; cur_sr = 15; cur_sc = 29;
        clear_stats();
        pulse_start(vecs[2]);
        for (int k = 0; k < 2000 && n_zero < 480; k++) @(negedge clk);
        check("rstmid_cleared", n_zero, 480);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_wr_en", int'(mem_wr_en), 0);
        check("rstmid_placed", int'(placed), 0);
        rst = 1'b0;
        run_case(vecs[0]);

        // Expert boards started at random times.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            v = '{16, 30, 99, 15, 29, model_n(16, 30, 99, 15, 29), "random"};
            run_case(v);
            maps[i] = ones_map;
        end
        begin
            int same = 0;
            for (int i = 0; i < 20; i++)
                for (int j = i + 1; j < 20; j++)
                    if (maps[i] == maps[j]) same++;
            check("random_maps_differ", same, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
- Downstream of the game-control FSM; runs while the FSM is in NEW_GAME.
- On a `start` pulse it clears the mine map in board RAM, then places `mine_count` mines at pseudo-random cells. It never places a mine on the first-clicked (safe) cell.
- Pulses `done` back to the FSM, which then enters PLAY.
- Randomness comes from a free-running LFSR, so the layout depends on when the player clicks.

Parameters:
- MAX_ROWS, 16, maximum board rows.
- MAX_COLS, 30, maximum board columns.
- ROW_W, 5, row index width (2^ROW_W >= MAX_ROWS).
- COL_W, 5, column index width (2^COL_W >= MAX_COLS).
- ADDR_W, 9, board address width, equal to clog2(MAX_ROWS*MAX_COLS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request from the game FSM; ignored while busy.
- rows  in  ROW_W  active board rows, 1..MAX_ROWS; sampled at start.
- cols  in  COL_W  active board columns, 1..MAX_COLS; sampled at start.
- mine_count  in  7  requested mines; sampled at start.
- safe_row  in  ROW_W  first-click row; sampled at start.
- safe_col  in  COL_W  first-click column; sampled at start.
- mem_rd_addr  out  ADDR_W  board RAM read address.
- mem_rd_data  in  1  mine bit; valid exactly 1 cycle after the address.
- mem_wr_en  out  1  board RAM write strobe.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  1  mine bit to write.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- placed  out  7  number of mines actually placed; holds its value until the next start.

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = 16'hACE1.
- Address mapping: addr = row*MAX_COLS + col.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle, including IDLE.
  - Never zero. If it is ever 0 it is forced back to 16'hACE1.
- Effective mine count N = min(mine_count, rows*cols-1).
- States:
  - IDLE: on start, latch all inputs, clear `placed`, set idx=0, go to CLEAR.
  - CLEAR: write 0 to address idx, one cell per cycle, over all MAX_ROWS*MAX_COLS cells (480 cycles). After the last address: go to DONE if N==0, else DRAW.
  - DRAW: candidate r = lfsr[ROW_W-1:0], c = lfsr[ROW_W+COL_W-1:ROW_W].
    - Reject the candidate and stay in DRAW if r>=rows, c>=cols, or it hits the safe cell/zone.
    - Otherwise drive mem_rd_addr and go to CHECK.
  - CHECK: mem_rd_data is now valid.
    - If 1 (cell already mined): back to DRAW.
    - If 0: go to WRITE.
  - WRITE: mem_wr_en=1, mem_wr_data=1; placed++. Go to DONE if placed+1==N, else DRAW.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- mem_wr_en is high only in CLEAR and WRITE.
- A start that arrives while not in IDLE is dropped; no queuing.
- Reset during operation: returns to IDLE immediately with outputs zeroed. RAM contents are then undefined; the FSM must restart.
- Latency: minimum 480 + 1 + 3N + 1 cycles. No upper bound is guaranteed, because rejection sampling can loop.

Optional Feature:
- Macro: MINE_PLACER_SAFE_ZONE_EN.
- Defined:
  - The excluded zone is the 3x3 neighbourhood of (safe_row, safe_col), clipped at board edges.
  - N = min(mine_count, rows*cols - zone_cells), where zone_cells is 4, 6 or 9 depending on position.
- Undefined: only the single safe cell is excluded.

Decomposition:
- game_pkg holds:
  - MAX_ROWS/MAX_COLS defaults;
  - the difficulty presets: 9x9/10, 16x16/40, 16x30/99;
  - the placer state typedef (IDLE, CLEAR, DRAW, CHECK, WRITE, DONE);
  - the LFSR seed constant.
- Sub-module lfsr16 (clk, rst, out[15:0]) is free-running and reusable elsewhere in the game.

Test Plan:
- rows=9, cols=9, mine_count=10, safe=(4,4), start pulse:
  - exactly 10 writes of 1, no duplicates, none at addr 124;
  - done pulses once; placed=10.
- Same run, CLEAR phase: 480 consecutive writes of 0 to addr 0..479 before any 1-write.
- rows=2, cols=2, mine_count=99, safe=(0,0): N clamps to 3; addrs 1, 30, 31 mined; placed=3.
  - With MINE_PLACER_SAFE_ZONE_EN: N=0, done directly after CLEAR, placed=0.
- Second start pulse 5 cycles after the first: ignored; exactly one done pulse.
- rst asserted 20 cycles into DRAW: next cycle busy=0, mem_wr_en=0, placed=0. A new start then completes normally.
- rows=16, cols=30, mine_count=99, safe=(15,29), 20 starts issued at random spacing:
  - each run gives placed=99;
  - all candidates lie within bounds;
  - the mine maps differ between runs.
